// File: rtl/lorenz_euler_core_pkg.sv
// Shared constants for the Lorenz Euler core: config addresses, FSM encoding,
// and helpers that quantise the default coefficients to a given fraction width.
package lorenz_pkg;

  localparam logic [2:0] ADDR_SIGMA = 3'd0;
  localparam logic [2:0] ADDR_RHO   = 3'd1;
  localparam logic [2:0] ADDR_BETA  = 3'd2;
  localparam logic [2:0] ADDR_H     = 3'd3;
  localparam logic [2:0] ADDR_X0    = 3'd4;
  localparam logic [2:0] ADDR_Y0    = 3'd5;
  localparam logic [2:0] ADDR_Z0    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE, ST_S1, ST_S2, ST_S3, ST_S4, ST_DONE
  } state_e;

  // floor(num/den * 2^frac); callers truncate to their word width
  function automatic logic [63:0] fx_const(int num, int den, int frac);
    return (64'(num) << frac) / 64'(den);
  endfunction

endpackage

// File: rtl/lorenz_euler_core_fx_mul.sv
// Signed Width x Width fixed-point multiply keeping bits [Frac+Width-1:Frac].
// LORENZ_SAT_EN: clamp to the signed range on overflow and flag it.
module fx_mul #(
  parameter int Width = 32,
  parameter int Frac  = 22
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] p_o,
  output logic             ovf_o
);
  logic [2*Width-1:0] prod;
  logic               unused_lo;

  assign prod      = {{Width{a_i[Width-1]}}, a_i} * {{Width{b_i[Width-1]}}, b_i};
  assign unused_lo = ^prod[Frac-1:0];

`ifdef LORENZ_SAT_EN
  logic hi_ok;
  // in range only when every dropped high bit copies the kept sign bit
  assign hi_ok = (prod[2*Width-1:Frac+Width-1] == {(Width-Frac+1){prod[Frac+Width-1]}});

  always_comb begin
    ovf_o = ~hi_ok;
    p_o   = prod[Frac+Width-1:Frac];
    if (!hi_ok) p_o = prod[2*Width-1] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
  end
`else
  logic unused_hi;
  assign unused_hi = ^prod[2*Width-1:Frac+Width];
  assign p_o       = prod[Frac+Width-1:Frac];
  assign ovf_o     = 1'b0;
`endif

endmodule

// File: rtl/lorenz_euler_core.sv
// Forward-Euler Lorenz iterator: S1..S4 multicycle datapath, runtime-loadable coefficients.
// Define LORENZ_SAT_EN for saturating add/sub/multiply and a sticky ovf_o.
module lorenz_euler_core
  import lorenz_pkg::*;
#(
  parameter int Width    = 32,
  parameter int Frac     = 22,
  parameter int CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                cfg_we_i,
  input  logic [2:0]          cfg_addr_i,
  input  logic [Width-1:0]    cfg_data_i,
  input  logic [CntWidth-1:0] steps_i,
  output logic                busy_o,
  output logic                valid_o,
  output logic                done_o,
  output logic                ovf_o,
  output logic [CntWidth-1:0] step_cnt_o,
  output logic [Width-1:0]    xn_o,
  output logic [Width-1:0]    yn_o,
  output logic [Width-1:0]    zn_o
);
  localparam logic [Width-1:0] SIGMA_RST = Width'(fx_const(10, 1, Frac));
  localparam logic [Width-1:0] RHO_RST   = Width'(fx_const(28, 1, Frac));
  localparam logic [Width-1:0] BETA_RST  = Width'(fx_const(8, 3, Frac));
  localparam logic [Width-1:0] H_RST     = Width'(fx_const(1, 256, Frac));
  localparam logic [Width-1:0] ONE_RST   = Width'(fx_const(1, 1, Frac));

  // returns {overflow, result}; b is subtracted when sub is set
  function automatic logic [Width:0] fx_addsub(logic [Width-1:0] a, logic [Width-1:0] b, logic sub);
    logic [Width-1:0] bb, s;
    bb = sub ? ~b : b;
    s  = a + bb + Width'(sub);
`ifdef LORENZ_SAT_EN
    if ((a[Width-1] == bb[Width-1]) && (s[Width-1] != a[Width-1]))
      return {1'b1, a[Width-1] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}}};
`endif
    return {1'b0, s};
  endfunction

  state_e state_q, state_d;
  logic [Width-1:0] sigma_q, rho_q, beta_q, h_q, x0_q, y0_q, z0_q;
  logic [Width-1:0] x_q, y_q, z_q, d1_q, d2_q, p1_q, p2_q, q1_q, q2_q, q3_q, e1_q, e2_q, e3_q;
  logic [CntWidth-1:0] cnt_q, steps_q;
  logic stop_q, valid_q, ovf_q;

  logic [Width-1:0] d1_c, d2_c, q3_c, r2_c, x_c, y_c, z_c;
  logic [6:0] add_ov, mul_ov;
  logic [6:0][Width-1:0] mul_a, mul_b, mul_p;
  logic busy, start_ok, last_it, stage_ov;

  assign busy     = (state_q == ST_S1) || (state_q == ST_S2) || (state_q == ST_S3) || (state_q == ST_S4);
  assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_it  = ((steps_q != '0) && (cnt_q + CntWidth'(1) == steps_q)) || stop_q || stop_i;

  always_comb begin
    add_ov = '0;
    {add_ov[0], d1_c} = fx_addsub(y_q, x_q, 1'b1);
    {add_ov[1], d2_c} = fx_addsub(rho_q, z_q, 1'b1);
    {add_ov[2], q3_c} = fx_addsub(p1_q, p2_q, 1'b1);
    {add_ov[3], r2_c} = fx_addsub(q2_q, y_q, 1'b1);
    {add_ov[4], x_c}  = fx_addsub(x_q, e1_q, 1'b0);
    {add_ov[5], y_c}  = fx_addsub(y_q, e2_q, 1'b0);
    {add_ov[6], z_c}  = fx_addsub(z_q, e3_q, 1'b0);
    mul_a[0] = x_q;     mul_b[0] = y_q;
    mul_a[1] = beta_q;  mul_b[1] = z_q;
    mul_a[2] = sigma_q; mul_b[2] = d1_q;
    mul_a[3] = x_q;     mul_b[3] = d2_q;
    mul_a[4] = h_q;     mul_b[4] = q1_q;
    mul_a[5] = h_q;     mul_b[5] = r2_c;
    mul_a[6] = h_q;     mul_b[6] = q3_q;
  end

  for (genvar i = 0; i < 7; i++) begin : g_mul
    fx_mul #(.Width(Width), .Frac(Frac)) u_mul (
      .a_i(mul_a[i]), .b_i(mul_b[i]), .p_o(mul_p[i]), .ovf_o(mul_ov[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    stage_ov = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_S1;
      ST_S1: begin state_d = ST_S2; stage_ov = |{add_ov[1:0], mul_ov[1:0]}; end
      ST_S2: begin state_d = ST_S3; stage_ov = |{add_ov[2], mul_ov[3:2]}; end
      ST_S3: begin state_d = ST_S4; stage_ov = |{add_ov[3], mul_ov[6:4]}; end
      ST_S4: begin state_d = last_it ? ST_DONE : ST_S1; stage_ov = |add_ov[6:4]; end
      ST_DONE: state_d = start_i ? ST_S1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sigma_q <= SIGMA_RST; rho_q <= RHO_RST; beta_q <= BETA_RST; h_q <= H_RST;
      x0_q <= ONE_RST; y0_q <= ONE_RST; z0_q <= ONE_RST;
    end else if (cfg_we_i && !busy) begin
      case (cfg_addr_i)
        ADDR_SIGMA: sigma_q <= cfg_data_i;
        ADDR_RHO:   rho_q   <= cfg_data_i;
        ADDR_BETA:  beta_q  <= cfg_data_i;
        ADDR_H:     h_q     <= cfg_data_i;
        ADDR_X0:    x0_q    <= cfg_data_i;
        ADDR_Y0:    y0_q    <= cfg_data_i;
        ADDR_Z0:    z0_q    <= cfg_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      {x_q, y_q, z_q, d1_q, d2_q, p1_q, p2_q} <= '0;
      {q1_q, q2_q, q3_q, e1_q, e2_q, e3_q} <= '0;
      cnt_q <= '0; steps_q <= '0;
      stop_q <= 1'b0; valid_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= 1'b0;
      ovf_q   <= start_ok ? 1'b0 : (ovf_q | stage_ov);
      if (busy && stop_i) stop_q <= 1'b1;
      if (start_ok || state_d == ST_DONE) stop_q <= 1'b0;
      if (start_ok) begin
        x_q <= x0_q; y_q <= y0_q; z_q <= z0_q;
        cnt_q <= '0; steps_q <= steps_i;
      end
      case (state_q)
        ST_S1: begin d1_q <= d1_c; d2_q <= d2_c; p1_q <= mul_p[0]; p2_q <= mul_p[1]; end
        ST_S2: begin q1_q <= mul_p[2]; q2_q <= mul_p[3]; q3_q <= q3_c; end
        ST_S3: begin e1_q <= mul_p[4]; e2_q <= mul_p[5]; e3_q <= mul_p[6]; end
        ST_S4: begin
          x_q <= x_c; y_q <= y_c; z_q <= z_c;
          cnt_q   <= cnt_q + CntWidth'(1);
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o     = busy;
  assign valid_o    = valid_q;
  assign done_o     = (state_q == ST_DONE);
  assign ovf_o      = ovf_q;
  assign step_cnt_o = cnt_q;
  assign xn_o       = x_q;
  assign yn_o       = y_q;
  assign zn_o       = z_q;

endmodule

// File: tb/tb_lorenz_euler_core.sv
// Directed bench for lorenz_euler_core: vector table of runs plus reset/overflow sequences.
module tb_lorenz_euler_core;
  logic        clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, stop_i = 1'b0, cfg_we_i = 1'b0;
  logic [2:0]  cfg_addr_i = 3'd0;
  logic [31:0] cfg_data_i = '0, steps_i = '0;
  logic        busy_o, valid_o, done_o, ovf_o;
  logic [31:0] step_cnt_o, xn_o, yn_o, zn_o;

  lorenz_euler_core dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i), .steps_i(steps_i),
    .busy_o(busy_o), .valid_o(valid_o), .done_o(done_o), .ovf_o(ovf_o),
    .step_cnt_o(step_cnt_o), .xn_o(xn_o), .yn_o(yn_o), .zn_o(zn_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [6:0][31:0] cfg;
    int steps, stop_it, poke_k, nval;
    logic [31:0] ex, ey, ez;
  } vec_t;

  localparam longint MAXV = 64'sh7FFFFFFF;
  localparam longint MINV = -64'sh80000000;

  int tests = 0, fails = 0, nv;
  bit m_ov;
  vec_t tv[5];
  logic [6:0][31:0] def_c, c;
  logic [31:0] mx, my, mz;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_fix(longint v);
`ifdef LORENZ_SAT_EN
    if (v > MAXV) begin m_ov = 1'b1; return 32'h7FFFFFFF; end
    if (v < MINV) begin m_ov = 1'b1; return 32'h80000000; end
`endif
    return v[31:0];
  endfunction
  function automatic logic [31:0] m_add(logic [31:0] a, logic [31:0] b);
    return m_fix(longint'(signed'(a)) + longint'(signed'(b)));
  endfunction
  function automatic logic [31:0] m_sub(logic [31:0] a, logic [31:0] b);
    return m_fix(longint'(signed'(a)) - longint'(signed'(b)));
  endfunction
  function automatic logic [31:0] m_mul(logic [31:0] a, logic [31:0] b);
    longint p;
    p = longint'(signed'(a)) * longint'(signed'(b));
    return m_fix(p >>> 22);
  endfunction

  // cfg index: 0 sigma, 1 rho, 2 beta, 3 h, 4 x0, 5 y0, 6 z0
  task automatic model(input logic [6:0][31:0] cf, input int n,
                       output logic [31:0] x, output logic [31:0] y, output logic [31:0] z);
    logic [31:0] d1, d2, p1, p2, q1, q2, q3, e1, e2, e3;
    x = cf[4]; y = cf[5]; z = cf[6];
    for (int i = 0; i < n; i++) begin
      d1 = m_sub(y, x);      d2 = m_sub(cf[1], z);
      p1 = m_mul(x, y);      p2 = m_mul(cf[2], z);
      q1 = m_mul(cf[0], d1); q2 = m_mul(x, d2); q3 = m_sub(p1, p2);
      e1 = m_mul(cf[3], q1); e2 = m_mul(cf[3], m_sub(q2, y)); e3 = m_mul(cf[3], q3);
      x = m_add(x, e1); y = m_add(y, e2); z = m_add(z, e3);
    end
  endtask

  task automatic cfg_write(input int a, input logic [31:0] d);
    cfg_we_i = 1'b1; cfg_addr_i = 3'(a); cfg_data_i = d;
    @(posedge clk_i); #1;
    cfg_we_i = 1'b0;
  endtask

  // stop_it>0: pulse stop in S2 of that iteration; -1: stop together with start.
  // poke_k: cycle at which start and an x0 write are attempted while busy.
  task automatic run(input string nm, input int steps, input int stop_it, input int poke_k, output int nval);
    int k;
    bit done_seen;
    steps_i = 32'(steps); start_i = 1'b1; stop_i = (stop_it < 0);
    @(posedge clk_i); #1;
    start_i = 1'b0; stop_i = 1'b0; steps_i = 32'hDEAD_BEEF;
    nval = 0; done_seen = 1'b0; k = 0;
    while (!done_seen && k < 400) begin
      @(posedge clk_i); #1;
      k++;
      stop_i = (stop_it > 0) && (k == 4 * (stop_it - 1) + 1);
      start_i = (k == poke_k); cfg_we_i = (k == poke_k);
      cfg_addr_i = 3'd4; cfg_data_i = 32'h12345678;
      chk({nm, " busy"}, busy_o, !done_o);
      if (valid_o) begin nval++; chk({nm, " valid timing"}, k, 4 * nval); end
      if (done_o) begin done_seen = 1'b1; chk({nm, " done with last valid"}, k, 4 * nval); end
    end
    start_i = 1'b0; stop_i = 1'b0; cfg_we_i = 1'b0;
    chk({nm, " done reached"}, done_seen, 1);
  endtask

  task automatic chk_xyz(input string nm, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    chk({nm, " xn"}, xn_o, x);
    chk({nm, " yn"}, yn_o, y);
    chk({nm, " zn"}, zn_o, z);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    def_c[0] = 32'h02800000; def_c[1] = 32'h07000000; def_c[2] = 32'h00AAAAAA;
    def_c[3] = 32'h00004000; def_c[4] = 32'h00400000; def_c[5] = 32'h00400000;
    def_c[6] = 32'h00400000;

    tv[0] = '{cfg: def_c, steps: 1, stop_it: 0, poke_k: 0, nval: 1,
              ex: 32'h00400000, ey: 32'h00468000, ez: 32'h003F9555};
    model(def_c, 5, mx, my, mz);
    tv[1] = '{cfg: def_c, steps: 5, stop_it: -1, poke_k: 0, nval: 5, ex: mx, ey: my, ez: mz};
    model(def_c, 3, mx, my, mz);
    tv[2] = '{cfg: def_c, steps: 0, stop_it: 3, poke_k: 0, nval: 3, ex: mx, ey: my, ez: mz};
    c = def_c;
    c[0] = 32'h01000000; c[3] = 32'h00010000;
    c[4] = 32'h00800000; c[5] = 32'hFFC00000; c[6] = 32'h00200000;
    model(c, 4, mx, my, mz);
    tv[3] = '{cfg: c, steps: 4, stop_it: 0, poke_k: 0, nval: 4, ex: mx, ey: my, ez: mz};
    c = def_c;
    c[0] = '0; c[4] = '0; c[5] = '0; c[6] = '0;
    tv[4] = '{cfg: c, steps: 3, stop_it: 0, poke_k: 6, nval: 3, ex: '0, ey: '0, ez: '0};

    #3 rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("reset ctl", {busy_o, valid_o, done_o, ovf_o}, 4'b0);
    chk("reset cnt", step_cnt_o, 0);
    chk_xyz("reset", 32'h0, 32'h0, 32'h0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    cfg_write(7, 32'hFFFFFFFF);
    for (int i = 0; i < 5; i++) begin
      for (int a = 0; a < 7; a++) cfg_write(a, tv[i].cfg[a]);
      run($sformatf("vec%0d", i), tv[i].steps, tv[i].stop_it, tv[i].poke_k, nv);
      chk($sformatf("vec%0d valids", i), nv, tv[i].nval);
      chk($sformatf("vec%0d step_cnt", i), step_cnt_o, tv[i].nval);
      chk_xyz($sformatf("vec%0d", i), tv[i].ex, tv[i].ey, tv[i].ez);
      @(posedge clk_i); #1;
      chk($sformatf("vec%0d idle after", i), {busy_o, done_o, valid_o}, 3'b0);
    end

    // x0 write attempted while busy in vec4 must not have landed
    run("busy-write", 1, 0, 0, nv);
    chk_xyz("busy-write", 32'h0, 32'h0, 32'h0);

    // async reset in the middle of S3
    steps_i = '0; start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #2;
    rst_i = 1'b0; #1;
    chk("midrst ctl", {busy_o, valid_o, done_o, ovf_o}, 4'b0);
    chk("midrst cnt", step_cnt_o, 0);
    chk_xyz("midrst", 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk("midrst no done", done_o, 0);
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    run("post-rst", 1, 0, 0, nv);
    chk("post-rst valids", nv, 1);
    chk_xyz("post-rst", 32'h00400000, 32'h00468000, 32'h003F9555);

    // stop in IDLE is ignored; then an overflowing run
    stop_i = 1'b1; @(posedge clk_i); #1; stop_i = 1'b0;
    cfg_write(4, 32'h7F000000);
    cfg_write(5, 32'h80000000);
    c = def_c; c[4] = 32'h7F000000; c[5] = 32'h80000000;
    m_ov = 1'b0;
    model(c, 2, mx, my, mz);
    run("ovf", 2, 0, 0, nv);
    chk("ovf valids", nv, 2);
    chk_xyz("ovf", mx, my, mz);
    chk("ovf flag", ovf_o, m_ov);
    @(posedge clk_i); #1;
    chk("ovf sticky", ovf_o, m_ov);
    cfg_write(4, 32'h00400000);
    cfg_write(5, 32'h00400000);
    run("ovf-clear", 1, 0, 0, nv);
    chk("ovf cleared by start", ovf_o, 0);
    chk_xyz("ovf-clear", 32'h00400000, 32'h00468000, 32'h003F9555);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
